// File: rtl/txuart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package txuart_pkg;

  localparam int unsigned BAUD_W = 24;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/txuart_baud.sv
// Reloadable baud countdown: emits a one-cycle tick on the last cycle of
// every bit period. Restarted at each frame start, held while disabled.
module txuart_baud
  import txuart_pkg::*;
#(
  parameter logic [BAUD_W-1:0] UART_SETUP = 24'd217
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_restart,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [BAUD_W-1:0] RELOAD = UART_SETUP - 24'd1;

  generate
    if (UART_SETUP < 24'd2) begin : g_bad_setup
      $error("txuart_baud: UART_SETUP must be at least 2");
    end
  endgenerate

  logic [BAUD_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  // Countdown with reload on restart or on bit boundary.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= RELOAD;
    end else if (i_en) begin
      r_cnt <= r_cnt - BAUD_W'(1);
    end
  end

endmodule

// File: rtl/txuart_core.sv
// Byte-wide UART transmitter, LSB first, 8N1 by default.
// Define TXUART_PARITY_EN to insert an even-parity bit before the stop bit.
module txuart_core
  import txuart_pkg::*;
#(
  parameter logic [BAUD_W-1:0] UART_SETUP = 24'd217
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_uart_tx
);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_next;
  logic              r_tx;
  logic              w_tx_next;
  logic              w_tick;
  logic              w_busy;
  logic              w_accept;
`ifdef TXUART_PARITY_EN
  logic              r_parity;
`endif

  // Busy drops in the final stop cycle so a new byte can follow with no gap.
  assign w_busy    = (r_state != IDLE) && !((r_state == STOP) && w_tick);
  assign w_accept  = i_wr && !w_busy;
  assign o_busy    = w_busy;
  assign o_uart_tx = r_tx;

  txuart_baud #(
    .UART_SETUP(UART_SETUP)
  ) u_baud (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_restart (w_accept),
    .i_en      (r_state != IDLE),
    .o_tick    (w_tick)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: advance one state per bit boundary.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_next = START;
      START: if (w_tick) w_state_next = DATA;
      DATA: begin
        if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef TXUART_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef TXUART_PARITY_EN
      PARITY: if (w_tick) w_state_next = STOP;
`endif
      STOP:  if (w_tick) w_state_next = w_accept ? START : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Shift register and bit index next values.
  always_comb begin
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    if (w_accept) begin
      w_shift_next   = i_data;
      w_bit_idx_next = '0;
    end else if ((r_state == DATA) && w_tick) begin
      w_shift_next   = {1'b0, r_shift[DATA_W-1:1]};
      w_bit_idx_next = r_bit_idx + 3'd1;
    end
  end

  // Line level for the coming cycle, derived from next state so the
  // registered output lines up exactly with the state it belongs to.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START:  w_tx_next = 1'b0;
      DATA:   w_tx_next = w_shift_next[0];
`ifdef TXUART_PARITY_EN
      PARITY: w_tx_next = r_parity;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
`ifdef TXUART_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
`ifdef TXUART_PARITY_EN
      if (w_accept) r_parity <= ^i_data;
`endif
    end
  end

endmodule

// File: tb/tb_txuart_core.sv
// Directed bench for txuart_core with UART_SETUP=4.
module tb_txuart_core;

  localparam int N = 4;
`ifdef TXUART_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int FRAME = 11 * N;
`else
  localparam bit PAR   = 1'b0;
  localparam int FRAME = 10 * N;
`endif

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_wr;
  logic [7:0] i_data;
  logic       o_busy;
  logic       o_uart_tx;

  int n_cmp = 0;
  int n_err = 0;

  txuart_core #(
    .UART_SETUP(24'd4)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_wr      (i_wr),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_uart_tx (o_uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present a byte so it is accepted at the next rising edge.
  task automatic start_wr(input logic [7:0] d);
    i_wr   = 1'b1;
    i_data = d;
    @(posedge clk);
    #1;
  endtask

  // Sample one full frame (cycles T+1..T+FRAME) and check it against the
  // expected waveform built from the byte value.
  task automatic run_frame(input string tag, input logic [7:0] exp, input bit keep_wr,
                           input int inj_k);
    int         bad = 0;
    int         busy_hi = 0;
    logic       last_busy = 1'b1;
    logic [7:0] dec = '0;
    logic       par_seen = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      int   b;
      logic e;
      @(negedge clk);
      b = (k - 1) / N;
      if (b == 0) e = 1'b0;
      else if (b <= 8) e = exp[b-1];
      else if (PAR && (b == 9)) e = ^exp;
      else e = 1'b1;
      if (o_uart_tx !== e) bad++;
      if (o_busy === 1'b1) busy_hi++;
      if (k == FRAME) last_busy = o_busy;
      if (((k - 1) % N) == N / 2) begin
        if ((b >= 1) && (b <= 8)) dec[b-1] = o_uart_tx;
        if (PAR && (b == 9)) par_seen = o_uart_tx;
      end
      if (!keep_wr && (k == 1)) i_wr = 1'b0;
      if ((inj_k != 0) && (k == inj_k)) begin
        i_wr   = 1'b1;
        i_data = 8'hFF;
      end
      if ((inj_k != 0) && (k == inj_k + 3)) i_wr = 1'b0;
    end
    chk({tag, "_line_bad_cycles"}, bad, 0);
    chk({tag, "_busy_hi_cycles"}, busy_hi, FRAME - 1);
    chk({tag, "_busy_last"}, last_busy, 0);
    chk({tag, "_byte"}, dec, exp);
    if (PAR) chk({tag, "_parity"}, par_seen, ^exp);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    int bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if ((o_uart_tx !== 1'b1) || (o_busy !== 1'b0)) bad++;
    end
    chk({tag, "_idle_bad_cycles"}, bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0;
    i_wr      = 1'b1;
    i_data    = 8'h55;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_tx", o_uart_tx, 1);
      chk("rst_busy", o_busy, 0);
    end
    i_wr      = 1'b0;
    i_reset_n = 1'b1;
    check_idle("post_rst", 3);

    // Single frame, alternating pattern.
    start_wr(8'h55);
    run_frame("f55", 8'h55, 1'b0, 0);
    check_idle("after55", 2);

    // Back-to-back frames with write held.
    start_wr(8'h41);
    i_data = 8'h0A;
    run_frame("b2b_41", 8'h41, 1'b1, 0);
    run_frame("b2b_0A", 8'h0A, 1'b0, 0);
    check_idle("after_b2b", 2);

    // Write while busy must be ignored.
    start_wr(8'h00);
    run_frame("ign_00", 8'h00, 1'b0, 14);
    check_idle("after_ign", 2 * N);

    // Reset during data bit 3 of 0xF0.
    start_wr(8'hF0);
    i_wr = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_rst_bit3", o_uart_tx, 0);
    chk("pre_rst_busy", o_busy, 1);
    i_reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", o_uart_tx, 1);
    chk("mid_rst_busy", o_busy, 0);
    i_reset_n = 1'b1;
    check_idle("after_mid_rst", 2);
    start_wr(8'hA5);
    run_frame("fA5", 8'hA5, 1'b0, 0);

`ifdef TXUART_PARITY_EN
    start_wr(8'h07);
    run_frame("par07", 8'h07, 1'b0, 0);
    start_wr(8'h03);
    run_frame("par03", 8'h03, 1'b0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
